// File: rtl/control_sequencer_if.sv
// Control-unit bundle: instruction/flag inputs to the sequencer and the
// control word it drives back out to the datapath.
interface control_sequencer_if;
    logic [3:0] opcode;
    logic       carry;
    logic       zero;
    logic       halt;
    logic       mar_in;
    logic       ram_in;
    logic       ram_out;
    logic       ir_in;
    logic       ir_out;
    logic       a_in;
    logic       a_out;
    logic       b_in;
    logic       alu_out;
    logic       alu_sub;
    logic       flags_in;
    logic       out_in;
    logic       pc_inc;
    logic       pc_out;
    logic       pc_jump;
    logic [2:0] step;

    modport master (
        input  opcode, carry, zero,
        output halt, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in,
               alu_out, alu_sub, flags_in, out_in, pc_inc, pc_out, pc_jump, step
    );

    modport slave (
        output opcode, carry, zero,
        input  halt, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out, b_in,
               alu_out, alu_sub, flags_in, out_in, pc_inc, pc_out, pc_jump, step
    );
endinterface

// File: rtl/control_sequencer.sv
// Microcoded control unit of the 8-bit CPU: step counter plus a decoded
// control word per (step, opcode, flags); a latched halt freezes everything.
module control_sequencer #(
    parameter int unsigned NUM_STEPS = 5,
    parameter bit          EARLY_END = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    control_sequencer_if.master bus
);
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0     = 3'd0;
    localparam logic [2:0] T1     = 3'd1;
    localparam logic [2:0] T2     = 3'd2;
    localparam logic [2:0] T3     = 3'd3;
    localparam logic [2:0] T4     = 3'd4;
    localparam logic [2:0] T_LAST = 3'(NUM_STEPS - 1);

    typedef struct packed {
        logic mar_in;
        logic ram_in;
        logic ram_out;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic flags_in;
        logic out_in;
        logic pc_inc;
        logic pc_out;
        logic pc_jump;
    } ctrl_t;

    logic [2:0] step_r;
    logic       halted_r;
    logic       hlt_now_s;
    logic       end_s;
    ctrl_t      ctrl_s;

    // Last step that carries any work; a not-taken conditional jump still ends at T2.
    function automatic logic [2:0] last_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA:                                 return T3;
            OP_ADD, OP_SUB:                                 return T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   return T2;
            default:                                        return T1;
        endcase
    endfunction

    assign hlt_now_s = (step_r == T2) && (bus.opcode == OP_HLT);
    assign end_s     = (EARLY_END && (step_r == last_step(bus.opcode))) || (step_r == T_LAST);

    // Control word decode; flags are looked at only when T2 is actually reached.
    always_comb begin
        ctrl_s = '0;
        if (halted_r) begin
            ctrl_s = '0;
        end else begin
            case (step_r)
                T0: begin
                    ctrl_s.pc_out = 1'b1;
                    ctrl_s.mar_in = 1'b1;
                end
                T1: begin
                    ctrl_s.ram_out = 1'b1;
                    ctrl_s.ir_in   = 1'b1;
                    ctrl_s.pc_inc  = 1'b1;
                end
                T2: begin
                    case (bus.opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl_s.ir_out = 1'b1;
                            ctrl_s.mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl_s.ir_out = 1'b1;
                            ctrl_s.a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl_s.ir_out  = 1'b1;
                            ctrl_s.pc_jump = 1'b1;
                        end
                        OP_JC, OP_JZ: begin
                            if ((bus.opcode == OP_JC) ? bus.carry : bus.zero) begin
                                ctrl_s.ir_out  = 1'b1;
                                ctrl_s.pc_jump = 1'b1;
                            end else begin
                                ctrl_s = '0;
                            end
                        end
                        OP_OUT: begin
                            ctrl_s.a_out  = 1'b1;
                            ctrl_s.out_in = 1'b1;
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                T3: begin
                    case (bus.opcode)
                        OP_LDA: begin
                            ctrl_s.ram_out = 1'b1;
                            ctrl_s.a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl_s.ram_out = 1'b1;
                            ctrl_s.b_in    = 1'b1;
                        end
                        OP_STA: begin
                            ctrl_s.a_out  = 1'b1;
                            ctrl_s.ram_in = 1'b1;
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                T4: begin
                    case (bus.opcode)
                        OP_ADD, OP_SUB: begin
                            ctrl_s.alu_out  = 1'b1;
                            ctrl_s.a_in     = 1'b1;
                            ctrl_s.flags_in = 1'b1;
                            ctrl_s.alu_sub  = (bus.opcode == OP_SUB);
                        end
                        default: ctrl_s = '0;
                    endcase
                end
                default: ctrl_s = '0;
            endcase
        end
    end

    // Step counter and halt latch; HLT at T2 parks the counter there until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_r   <= T0;
            halted_r <= 1'b0;
        end else if (halted_r || hlt_now_s) begin
            step_r   <= step_r;
            halted_r <= 1'b1;
        end else if (end_s) begin
            step_r   <= T0;
            halted_r <= 1'b0;
        end else begin
            step_r   <= step_r + 3'd1;
            halted_r <= 1'b0;
        end
    end

    assign bus.halt     = halted_r | hlt_now_s;
    assign bus.mar_in   = ctrl_s.mar_in;
    assign bus.ram_in   = ctrl_s.ram_in;
    assign bus.ram_out  = ctrl_s.ram_out;
    assign bus.ir_in    = ctrl_s.ir_in;
    assign bus.ir_out   = ctrl_s.ir_out;
    assign bus.a_in     = ctrl_s.a_in;
    assign bus.a_out    = ctrl_s.a_out;
    assign bus.b_in     = ctrl_s.b_in;
    assign bus.alu_out  = ctrl_s.alu_out;
    assign bus.alu_sub  = ctrl_s.alu_sub;
    assign bus.flags_in = ctrl_s.flags_in;
    assign bus.out_in   = ctrl_s.out_in;
    assign bus.pc_inc   = ctrl_s.pc_inc;
    assign bus.pc_out   = ctrl_s.pc_out;
    assign bus.pc_jump  = ctrl_s.pc_jump;
    assign bus.step     = step_r;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction table run on an EARLY_END=1 and an
// EARLY_END=0 instance, expected words queued by the driver and popped by a monitor.
module tb_control_sequencer;
    localparam logic [15:0] W_HALT     = 16'h8000;
    localparam logic [15:0] W_MAR_IN   = 16'h4000;
    localparam logic [15:0] W_RAM_IN   = 16'h2000;
    localparam logic [15:0] W_RAM_OUT  = 16'h1000;
    localparam logic [15:0] W_IR_IN    = 16'h0800;
    localparam logic [15:0] W_IR_OUT   = 16'h0400;
    localparam logic [15:0] W_A_IN     = 16'h0200;
    localparam logic [15:0] W_A_OUT    = 16'h0100;
    localparam logic [15:0] W_B_IN     = 16'h0080;
    localparam logic [15:0] W_ALU_OUT  = 16'h0040;
    localparam logic [15:0] W_ALU_SUB  = 16'h0020;
    localparam logic [15:0] W_FLAGS_IN = 16'h0010;
    localparam logic [15:0] W_OUT_IN   = 16'h0008;
    localparam logic [15:0] W_PC_INC   = 16'h0004;
    localparam logic [15:0] W_PC_OUT   = 16'h0002;
    localparam logic [15:0] W_PC_JUMP  = 16'h0001;
    localparam logic [15:0] W_FETCH0   = W_PC_OUT | W_MAR_IN;
    localparam logic [15:0] W_FETCH1   = W_RAM_OUT | W_IR_IN | W_PC_INC;
    localparam logic [15:0] W_DRIVERS  = W_RAM_OUT | W_IR_OUT | W_A_OUT | W_ALU_OUT | W_PC_OUT;

    typedef struct {
        logic [3:0]  op;
        logic        carry;
        logic        zero;
        int          len;
        logic [15:0] w2;
        logic [15:0] w3;
        logic [15:0] w4;
    } vec_t;

    typedef struct {
        bit          sel;
        logic [2:0]  step;
        logic [15:0] word;
        logic [3:0]  op;
    } exp_t;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic       carry  = 1'b0;
    logic       zero   = 1'b0;

    exp_t q[$];
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    control_sequencer_if if1 ();
    control_sequencer_if if0 ();

    assign if1.opcode = opcode;
    assign if1.carry  = carry;
    assign if1.zero   = zero;
    assign if0.opcode = opcode;
    assign if0.carry  = carry;
    assign if0.zero   = zero;

    control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
    control_sequencer #(.NUM_STEPS(5), .EARLY_END(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));

    logic [15:0] w1;
    logic [15:0] w0;
    assign w1 = {if1.halt, if1.mar_in, if1.ram_in, if1.ram_out, if1.ir_in, if1.ir_out, if1.a_in,
                 if1.a_out, if1.b_in, if1.alu_out, if1.alu_sub, if1.flags_in, if1.out_in,
                 if1.pc_inc, if1.pc_out, if1.pc_jump};
    assign w0 = {if0.halt, if0.mar_in, if0.ram_in, if0.ram_out, if0.ir_in, if0.ir_out, if0.a_in,
                 if0.a_out, if0.b_in, if0.alu_out, if0.alu_sub, if0.flags_in, if0.out_in,
                 if0.pc_inc, if0.pc_out, if0.pc_jump};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act_step, input logic [2:0] exp_step,
                         input logic [15:0] act_word, input logic [15:0] exp_word);
        n_vec++;
        if (act_step !== exp_step || act_word !== exp_word) begin
            n_err++;
            $display("FAIL %s: step=%0d word=%h, required step=%0d word=%h",
                     name, act_step, act_word, exp_step, exp_word);
        end
    endtask

    task automatic bus_check(input string name, input logic [15:0] word);
        int n;
        n = $countones(word & W_DRIVERS);
        n_vec++;
        if (n > 1) begin
            n_err++;
            $display("FAIL %s: %0d bus drivers in word %h, required at most 1", name, n, word);
        end
    endtask

    task automatic push(input bit sel, input logic [2:0] st, input logic [15:0] word, input logic [3:0] op);
        exp_t e;
        e.sel  = sel;
        e.step = st;
        e.word = word;
        e.op   = op;
        q.push_back(e);
    endtask

    task automatic add_vec(input logic [3:0] op, input logic c, input logic z, input int len,
                           input logic [15:0] w2, input logic [15:0] w3, input logic [15:0] w4);
        vec_t v;
        v.op = op; v.carry = c; v.zero = z; v.len = len;
        v.w2 = w2; v.w3 = w3; v.w4 = w4;
        vecs.push_back(v);
    endtask

    // Flags are inverted during fetch so only their T2 value may matter.
    task automatic run_instr(input bit sel, input vec_t v, input int len);
        logic [15:0] w;
        for (int i = 0; i < len; i++) begin
            opcode = v.op;
            carry  = (i >= 2) ? v.carry : ~v.carry;
            zero   = (i >= 2) ? v.zero  : ~v.zero;
            case (i)
                0:       w = W_FETCH0;
                1:       w = W_FETCH1;
                2:       w = v.w2;
                3:       w = v.w3;
                default: w = v.w4;
            endcase
            push(sel, 3'(i), w, v.op);
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [2:0]  as;
        logic [15:0] aw;
        if (rst) begin
            bus_check("bus_ee1", w1);
            bus_check("bus_ee0", w0);
            if (q.size() > 0) begin
                e  = q.pop_front();
                as = e.sel ? if1.step : if0.step;
                aw = e.sel ? w1 : w0;
                check($sformatf("op%h_t%0d_ee%0d", e.op, e.step, e.sel), as, e.step, aw, e.word);
            end
        end
    end

    initial begin
        vec_t v;
        add_vec(4'h0, 1'b0, 1'b0, 2, 16'h0, 16'h0, 16'h0);
        add_vec(4'h1, 1'b0, 1'b0, 4, W_IR_OUT | W_MAR_IN, W_RAM_OUT | W_A_IN, 16'h0);
        add_vec(4'h2, 1'b0, 1'b0, 5, W_IR_OUT | W_MAR_IN, W_RAM_OUT | W_B_IN, W_ALU_OUT | W_A_IN | W_FLAGS_IN);
        add_vec(4'h3, 1'b0, 1'b0, 5, W_IR_OUT | W_MAR_IN, W_RAM_OUT | W_B_IN,
                W_ALU_OUT | W_A_IN | W_FLAGS_IN | W_ALU_SUB);
        add_vec(4'h4, 1'b0, 1'b0, 4, W_IR_OUT | W_MAR_IN, W_A_OUT | W_RAM_IN, 16'h0);
        add_vec(4'h5, 1'b0, 1'b0, 3, W_IR_OUT | W_A_IN, 16'h0, 16'h0);
        add_vec(4'h6, 1'b0, 1'b0, 3, W_IR_OUT | W_PC_JUMP, 16'h0, 16'h0);
        add_vec(4'h7, 1'b1, 1'b0, 3, W_IR_OUT | W_PC_JUMP, 16'h0, 16'h0);
        add_vec(4'h7, 1'b0, 1'b1, 3, 16'h0, 16'h0, 16'h0);
        add_vec(4'h8, 1'b0, 1'b1, 3, W_IR_OUT | W_PC_JUMP, 16'h0, 16'h0);
        add_vec(4'h8, 1'b1, 1'b0, 3, 16'h0, 16'h0, 16'h0);
        for (int op = 9; op <= 13; op++) add_vec(4'(op), 1'b0, 1'b0, 2, 16'h0, 16'h0, 16'h0);
        add_vec(4'hE, 1'b0, 1'b0, 3, W_A_OUT | W_OUT_IN, 16'h0, 16'h0);

        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold_ee1", if1.step, 3'd0, w1, W_FETCH0);
        check("reset_hold_ee0", if0.step, 3'd0, w0, W_FETCH0);
        rst = 1'b1;

        foreach (vecs[i]) run_instr(1'b1, vecs[i], vecs[i].len);

        // Abandon an ADD at T3 with an asynchronous reset.
        run_instr(1'b1, vecs[2], 3);
        check("add_t3", if1.step, 3'd3, w1, W_RAM_OUT | W_B_IN);
        #2 rst = 1'b0;
        #1 check("rst_mid_add", if1.step, 3'd0, w1, W_FETCH0);
        @(posedge clk);
        #1 rst = 1'b1;

        v.op = 4'hF; v.carry = 1'b0; v.zero = 1'b0; v.len = 3;
        v.w2 = W_HALT; v.w3 = 16'h0; v.w4 = 16'h0;
        run_instr(1'b1, v, 3);
        repeat (10) begin
            push(1'b1, 3'd2, W_HALT, 4'hF);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1 check("hlt_reset", if1.step, 3'd0, w1, W_FETCH0);
        @(posedge clk);
        #1 rst = 1'b1;

        foreach (vecs[i]) run_instr(1'b0, vecs[i], 5);
        push(1'b0, 3'd0, W_FETCH0, 4'h0);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit of the 8-bit CPU.
- Consumes the opcode nibble from the instruction register and the carry/zero flags latched by the ALU.
- Each cycle it drives the control word that gates the program counter, MAR, RAM, A/B/I registers, ALU and output module onto or off the shared bus.
- A step counter sequences fetch and execute; halt freezes it.

Parameters:
- NUM_STEPS, 5: micro-steps per instruction (T0..T4). The step counter is 3 bits wide.
- EARLY_END, 1: when 1, the counter returns to T0 after an opcode's last active step; when 0, every instruction takes NUM_STEPS cycles.

Ports:
- clk  in  1  CPU clock (cpu_clk from the clock module)
- rst  in  1  asynchronous, active-low reset
- opcode  in  4  instruction register bits [7:4]
- carry  in  1  ALU carry flag (registered)
- zero  in  1  ALU zero flag (registered)
- halt  out  1  CPU halted
- mar_in  out  1  MAR reads from the bus
- ram_in  out  1  RAM reads from the bus
- ram_out  out  1  RAM drives the bus
- ir_in  out  1  I register reads from the bus
- ir_out  out  1  I register drives the bus (low nibble)
- a_in  out  1  A register reads from the bus
- a_out  out  1  A register drives the bus
- b_in  out  1  B register reads from the bus
- alu_out  out  1  ALU drives the bus
- alu_sub  out  1  ALU subtract
- flags_in  out  1  ALU flags latch
- out_in  out  1  output module latches the bus
- pc_inc  out  1  PC increment
- pc_out  out  1  PC drives the bus
- pc_jump  out  1  PC loads from the bus
- step  out  3  current micro-step (LED debug)

Behaviour:
State and reset:
- Registered state is step[2:0] and halted.
- rst low (async) forces step=0 and halted=0.
- The control word is combinational from (step, opcode, carry, zero, halted). After reset it therefore equals the T0 word: pc_out=1, mar_in=1, all other outputs 0.

Fetch, all opcodes:
- T0: pc_out, mar_in.
- T1: ram_out, ir_in, pc_inc.

Execute steps (opcode hex):
- 0 NOP: nothing.
- 1 LDA: T2 ir_out+mar_in; T3 ram_out+a_in.
- 2 ADD: T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in+flags_in.
- 3 SUB: as ADD, but T4 also asserts alu_sub.
- 4 STA: T2 ir_out+mar_in; T3 a_out+ram_in.
- 5 LDI: T2 ir_out+a_in.
- 6 JMP: T2 ir_out+pc_jump.
- 7 JC: T2 ir_out+pc_jump only if carry=1; otherwise an all-zero word.
- 8 JZ: as JC, using zero.
- E OUT: T2 a_out+out_in.
- F HLT: T2 halt.
- 9–D: treated as NOP.

Last active step (EARLY_END=1):
- NOP/undefined: T1.
- LDI/JMP/JC/JZ/OUT: T2. A JC/JZ not taken still ends at T2.
- LDA/STA: T3.
- ADD/SUB: T4.

Step counter:
- On each rising clk edge: if halted or (step==T2 and opcode==F), step holds; else if at the last active step (EARLY_END=1) or step==NUM_STEPS-1, step becomes 0; else step increments.
- With EARLY_END=0, unused steps emit all-zero words.

Halt:
- Combinational halt=1 during HLT T2.
- The rising edge at HLT T2 sets halted.
- While halted: halt=1, every other control output is 0, step frozen at 2. Only rst clears it.

Other rules:
- Flags are sampled combinationally at T2. A flag change between T0 and T2 uses the T2 value.
- At most one bus driver (ram_out, ir_out, a_out, alu_out, pc_out) is asserted in any step, for every opcode.
- Reset mid-instruction abandons it; the next cycle fetches at T0.

Test Plan:
- Reset low, release -> step=0, pc_out=1, mar_in=1, all other outputs 0. Assert rst mid-ADD at T3 -> immediately step=0 with the T0 word.
- opcode=2 (ADD) -> steps 0,1,2,3,4,0. T3: ram_out=b_in=1. T4: alu_out=a_in=flags_in=1, alu_sub=0. opcode=3 (SUB) -> T4 alu_sub=1.
- opcode=5 (LDI) -> cycle 0,1,2,0. T2: ir_out=a_in=1. opcode=0 -> cycle 0,1,0. With EARLY_END=0, opcode=0 -> five steps, T2–T4 all zero.
- opcode=7 (JC), carry=1 -> T2: ir_out=pc_jump=1. carry=0 -> T2 word all zero, next step=0. opcode=8 (JZ) with zero=1/0 -> same pair of responses.
- opcode=F (HLT) -> T2 halt=1. Then 10 clocks -> step stays 2, halt=1, other outputs 0. Pulse rst -> step=0, halt=0.
- Sweep all 16 opcodes × 5 steps (EARLY_END=1 and 0) -> at most one bus driver per word; words match the table above.
